store_buffer_unit: RTL and testbench
====================================

STORE_BUFFER_UNIT -- requirements
Module: store_buffer_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered stores; legal values are powers of two, 2 to 16.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 st_valid  input  1  store request present.
REQ-006 st_ready  output  1  buffer can accept; SHALL equal !full.
REQ-007 st_control  input  3  store type (SB/SH/SW/STR_NOP, shared encodings).
REQ-008 st_addr  input  ADDR_W  byte address.
REQ-009 st_data  input  32  rs2 value; low bytes used per type.
REQ-010 mem_valid  output  1  head entry presented to memory.
REQ-011 mem_ready  input  1  memory accepts head entry.
REQ-012 mem_addr  output  ADDR_W  word-aligned address, bits [1:0] SHALL be 0.
REQ-013 mem_wdata  output  32  lane-steered write data.
REQ-014 mem_be  output  4  byte-lane write enables.
REQ-015 count  output  $clog2(DEPTH+1)  occupied entries.
REQ-016 empty, full  output  1 each  occupancy flags.
REQ-017 misalign_err  output  1  one-cycle pulse on a rejected misaligned store.

Function
REQ-018 A store SHALL be accepted on a cycle with st_valid and st_ready both high.
REQ-019 An accepted STR_NOP or undefined st_control SHALL complete the handshake and SHALL NOT be enqueued.
REQ-020 SB: mem_be = 1 shifted left by addr[1:0]; data byte replicated on all four lanes.
REQ-021 SH: mem_be = 4'b0011 shifted left by addr[1:0]; halfword replicated on both halves; aligned when addr[0]=0.
REQ-022 SW: mem_be = 4'b1111; data unchanged; aligned when addr[1:0]=0.
REQ-023 An enqueued entry SHALL appear on mem_valid no earlier than the cycle after acceptance; there is no combinational bypass.
REQ-024 mem_valid SHALL equal !empty; mem_addr/mem_wdata/mem_be SHALL hold the head entry, stable until a cycle with mem_valid and mem_ready both high pops it.
REQ-025 Entries SHALL drain in strict acceptance order.
REQ-026 On the same cycle, a push and a pop SHALL leave count unchanged and advance both pointers.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-028 When full, st_ready SHALL be low even if mem_ready is high that cycle.
REQ-029 mem_ready while empty SHALL have no effect.

Reset
REQ-030 Asserting rst SHALL immediately force pointers and count to 0, empty=1, full=0, mem_valid=0, misalign_err=0, and st_ready=1.
REQ-031 Reset mid-drain SHALL discard all buffered entries; storage array contents are not reset.

Configuration
REQ-032 With STORE_MISALIGN_TRAP_EN defined, a misaligned SH/SW SHALL be accepted but not enqueued, and misalign_err SHALL pulse high for exactly the following cycle.
REQ-033 Without STORE_MISALIGN_TRAP_EN, misaligned SH/SW SHALL be enqueued with the offending low address bits forced to 0 before lane steering, and misalign_err SHALL be tied 0.

Structure
REQ-034 A shared package store_pkg SHALL hold the store_control encodings, the buffer entry struct (addr, wdata, be), and the lane-steering function prototypes' constants.
REQ-035 Combinational lane steering and alignment checking SHALL live in sub-module store_align; store_buffer_unit holds the FIFO, pointers, and handshake.

Verification
REQ-036 After reset, SW addr 0x100 data 0xDEADBEEF with mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; popped that cycle; empty after.
REQ-037 SB addr 0x103 data 0x000000A5 -> mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5; SH addr 0x102 data 0x1234 -> mem_be=1100, mem_wdata=0x12341234.
REQ-038 mem_ready=0, push DEPTH+1 SW stores back-to-back -> full=1 and st_ready=0 after DEPTH accepts; raise mem_ready -> all drain in order across pointer wrap.
REQ-039 Buffer holding 2 entries, simultaneous push and pop for 6 cycles -> count stays 2, output order matches input order.
REQ-040 SW addr 0x102: with STORE_MISALIGN_TRAP_EN -> not enqueued, misalign_err high one cycle; without -> entry mem_addr=0x100, mem_be=1111, misalign_err=0.
REQ-041 rst asserted asynchronously with 3 entries queued and mem_valid=1 -> mem_valid, count, full, and misalign_err drop to 0 before the next clock edge; empty=1.

Source files
------------

// File: rtl/store_pkg.sv
// Shared store-buffer types: store_control encodings, buffered entry layout and lane-enable constants.
package store_pkg;

  typedef enum logic [2:0] {
    STR_SB  = 3'b000,
    STR_SH  = 3'b001,
    STR_SW  = 3'b010,
    STR_NOP = 3'b111
  } store_control_e;

  // Entry address is held at the widest supported width; the top slices it to ADDR_W.
  localparam int unsigned SB_ADDR_MAX_W = 64;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [SB_ADDR_MAX_W-1:0] addr;
    logic [31:0]              wdata;
    logic [3:0]               be;
  } sb_entry_t;

  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl)
      STR_SH:  return off[0];
      STR_SW:  return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_unit_if.sv
// Store request / memory write bundle; slave side is the buffer, master side feeds stores and accepts writes.
interface store_buffer_unit_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              st_valid;
  logic              st_ready;
  logic [2:0]        st_control;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              misalign_err;

  modport master (
    output st_valid, st_control, st_addr, st_data, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_wdata, mem_be, count, empty, full, misalign_err
  );

  modport slave (
    input  st_valid, st_control, st_addr, st_data, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_wdata, mem_be, count, empty, full, misalign_err
  );

endinterface

// File: rtl/store_align.sv
// Combinational lane steering and alignment check for one store; zero latency, no state.
// STORE_MISALIGN_TRAP_EN selects reject-and-flag instead of forcing low address bits to zero.
module store_align
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [2:0]        ctrl_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output sb_entry_t         entry_o,
  output logic              enq_o,
  output logic              misalign_o
);

  logic       known;
  logic [1:0] off;

  always_comb begin
    known = (ctrl_i == STR_SB) || (ctrl_i == STR_SH) || (ctrl_i == STR_SW);
`ifdef STORE_MISALIGN_TRAP_EN
    off        = addr_i[1:0];
    misalign_o = known && is_misaligned(ctrl_i, addr_i[1:0]);
    enq_o      = known && !misalign_o;
`else
    case (ctrl_i)
      STR_SH:  off = {addr_i[1], 1'b0};
      STR_SW:  off = 2'b00;
      default: off = addr_i[1:0];
    endcase
    misalign_o = 1'b0;
    enq_o      = known;
`endif
    entry_o = '0;
    entry_o.addr[ADDR_W-1:0] = {addr_i[ADDR_W-1:2], 2'b00};
    case (ctrl_i)
      STR_SB: begin
        entry_o.be    = BE_BYTE << off;
        entry_o.wdata = {4{data_i[7:0]}};
      end
      STR_SH: begin
        entry_o.be    = BE_HALF << off;
        entry_o.wdata = {2{data_i[15:0]}};
      end
      default: begin
        entry_o.be    = BE_WORD;
        entry_o.wdata = data_i;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer_unit.sv
// In-order store buffer of DEPTH entries; entries reach memory one cycle after acceptance, st_ready = !full.
// Optional STORE_MISALIGN_TRAP_EN: misaligned SH/SW are dropped and misalign_err pulses for one cycle.
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  store_buffer_unit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  sb_entry_t        slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_err_q, misalign_err_d;

  sb_entry_t new_entry;
  sb_entry_t head;
  logic      enq_ok, misalign;
  logic      full, empty, accept, push, pop;
  logic      unused_head_addr;

  store_align #(.ADDR_W(ADDR_W)) u_align (
    .ctrl_i     (bus.st_control),
    .addr_i     (bus.st_addr),
    .data_i     (bus.st_data),
    .entry_o    (new_entry),
    .enq_o      (enq_ok),
    .misalign_o (misalign)
  );

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign accept = bus.st_valid && !full;
  assign push   = accept && enq_ok;
  assign pop    = !empty && bus.mem_ready;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    misalign_err_d = accept && misalign;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= new_entry;
  end

  assign head             = slot_q[rd_ptr_q];
  assign unused_head_addr = ^head.addr;

  assign bus.st_ready     = !full;
  assign bus.mem_valid    = !empty;
  assign bus.mem_addr     = head.addr[ADDR_W-1:0];
  assign bus.mem_wdata    = head.wdata;
  assign bus.mem_be       = head.be;
  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.misalign_err = misalign_err_q;

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit: single-store vector table plus fill/drain, streaming and async-reset sequences.
module tb_store_buffer_unit;
  import store_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic clk;
  logic rst;

  store_buffer_unit_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  store_buffer_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] data;
    logic        enq;
    logic        err;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
  } vec_t;

  function automatic vec_t mkv(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                               input logic en, input logic er, input logic [31:0] ea,
                               input logic [3:0] eb, input logic [31:0] ew);
    vec_t v;
    v.ctrl = c; v.addr = a; v.data = d; v.enq = en; v.err = er;
    v.eaddr = ea; v.ebe = eb; v.ewdata = ew;
    return v;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sw_t;

  function automatic sw_t mk_sw(input logic [31:0] a, input logic [31:0] d);
    sw_t s;
    s.addr = a; s.data = d;
    return s;
  endfunction

  sw_t pend_q[$];
  sw_t exp_q[$];
  bit  rdy_on;

  // Reference FIFO model: drives pending SW stores, checks head/flags each cycle against expected queue.
  task automatic run_cycles(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      bit push_m, pop_m;
      if (pend_q.size() > 0) begin
        bus.st_valid   = 1'b1;
        bus.st_control = STR_SW;
        bus.st_addr    = pend_q[0].addr;
        bus.st_data    = pend_q[0].data;
      end else begin
        bus.st_valid   = 1'b0;
      end
      bus.mem_ready = rdy_on;
      #1;
      chk({tag, ".st_ready"}, bus.st_ready, exp_q.size() < DEPTH);
      chk({tag, ".full"}, bus.full, exp_q.size() == DEPTH);
      chk({tag, ".count"}, bus.count, exp_q.size());
      chk({tag, ".mem_valid"}, bus.mem_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk({tag, ".mem_addr"}, bus.mem_addr, exp_q[0].addr);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_q[0].data);
        chk({tag, ".mem_be"}, bus.mem_be, 4'hF);
      end
      push_m = (pend_q.size() > 0) && (exp_q.size() < DEPTH);
      pop_m  = rdy_on && (exp_q.size() > 0);
      @(posedge clk);
      if (pop_m) exp_q.delete(0);
      if (push_m) begin
        exp_q.push_back(pend_q[0]);
        pend_q.delete(0);
      end
      @(negedge clk);
    end
    bus.st_valid = 1'b0;
  endtask

  vec_t vt [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.st_valid   = 1'b0;
    bus.st_control = STR_NOP;
    bus.st_addr    = '0;
    bus.st_data    = '0;
    bus.mem_ready  = 1'b0;
    rdy_on         = 1'b0;

    vt[0] = mkv(STR_SW,  32'h100, 32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'hDEADBEEF);
    vt[1] = mkv(STR_SB,  32'h103, 32'h000000A5, 1, 0, 32'h100, 4'b1000, 32'hA5A5A5A5);
    vt[2] = mkv(STR_SH,  32'h102, 32'h00001234, 1, 0, 32'h100, 4'b1100, 32'h12341234);
    vt[3] = mkv(STR_SB,  32'h201, 32'hFFFFFF3C, 1, 0, 32'h200, 4'b0010, 32'h3C3C3C3C);
    vt[4] = mkv(STR_SH,  32'h200, 32'hABCD5678, 1, 0, 32'h200, 4'b0011, 32'h56785678);
    vt[5] = mkv(STR_NOP, 32'h300, 32'h11111111, 0, 0, 32'h0,   4'b0000, 32'h0);
    vt[6] = mkv(3'd5,    32'h304, 32'h22222222, 0, 0, 32'h0,   4'b0000, 32'h0);
`ifdef STORE_MISALIGN_TRAP_EN
    vt[7] = mkv(STR_SW,  32'h102, 32'hDEADBEEF, 0, 1, 32'h0,   4'b0000, 32'h0);
    vt[8] = mkv(STR_SH,  32'h107, 32'h0000BEEF, 0, 1, 32'h0,   4'b0000, 32'h0);
    vt[9] = mkv(STR_SW,  32'h103, 32'h11223344, 0, 1, 32'h0,   4'b0000, 32'h0);
`else
    vt[7] = mkv(STR_SW,  32'h102, 32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'hDEADBEEF);
    vt[8] = mkv(STR_SH,  32'h107, 32'h0000BEEF, 1, 0, 32'h104, 4'b1100, 32'hBEEFBEEF);
    vt[9] = mkv(STR_SW,  32'h103, 32'h11223344, 1, 0, 32'h100, 4'b1111, 32'h11223344);
`endif

    #1;
    chk("rst.empty", bus.empty, 1'b1);
    chk("rst.full", bus.full, 1'b0);
    chk("rst.count", bus.count, 0);
    chk("rst.mem_valid", bus.mem_valid, 1'b0);
    chk("rst.st_ready", bus.st_ready, 1'b1);
    chk("rst.misalign_err", bus.misalign_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // SW with memory ready: visible next cycle, popped in that cycle.
    bus.st_valid = 1'b1; bus.st_control = STR_SW; bus.st_addr = 32'h100;
    bus.st_data = 32'hDEADBEEF; bus.mem_ready = 1'b1;
    #1;
    chk("bypass.mem_valid", bus.mem_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    bus.st_valid = 1'b0;
    #1;
    chk("first.mem_valid", bus.mem_valid, 1'b1);
    chk("first.mem_addr", bus.mem_addr, 32'h100);
    chk("first.mem_be", bus.mem_be, 4'b1111);
    chk("first.mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("first.empty_after", bus.empty, 1'b1);
    chk("first.count_after", bus.count, 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.st_valid = 1'b1; bus.st_control = vt[i].ctrl;
      bus.st_addr = vt[i].addr; bus.st_data = vt[i].data; bus.mem_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d.st_ready", i), bus.st_ready, 1'b1);
      @(posedge clk); @(negedge clk);
      bus.st_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d.misalign_err", i), bus.misalign_err, vt[i].err);
      chk($sformatf("vec%0d.mem_valid", i), bus.mem_valid, vt[i].enq);
      if (vt[i].enq) begin
        chk($sformatf("vec%0d.mem_addr", i), bus.mem_addr, vt[i].eaddr);
        chk($sformatf("vec%0d.mem_be", i), bus.mem_be, vt[i].ebe);
        chk($sformatf("vec%0d.mem_wdata", i), bus.mem_wdata, vt[i].ewdata);
      end
      bus.mem_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d.empty_after", i), bus.empty, 1'b1);
      chk($sformatf("vec%0d.err_pulse_end", i), bus.misalign_err, 1'b0);
    end

    @(negedge clk);
    // DEPTH+1 back-to-back stores with memory stalled, then drain across pointer wrap.
    rdy_on = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) pend_q.push_back(mk_sw(32'h400 + 4 * i, 32'hC0DE0000 + i));
    run_cycles(DEPTH + 1, "fill");
    rdy_on = 1'b1;
    run_cycles(DEPTH + 3, "drain");
    chk("drain.all_out", exp_q.size() + pend_q.size(), 0);

    // Two entries resident, then six cycles of simultaneous push and pop.
    rdy_on = 1'b0;
    for (int i = 0; i < 2; i++) pend_q.push_back(mk_sw(32'h800 + 4 * i, 32'hA0000000 + i));
    run_cycles(2, "pre2");
    rdy_on = 1'b1;
    for (int i = 2; i < 8; i++) pend_q.push_back(mk_sw(32'h800 + 4 * i, 32'hA0000000 + i));
    run_cycles(6, "stream");
    run_cycles(4, "tail");
    chk("tail.all_out", exp_q.size() + pend_q.size(), 0);

    // Async reset with three queued entries plus one more store in flight.
    rdy_on = 1'b0;
    for (int i = 0; i < 3; i++) pend_q.push_back(mk_sw(32'hC00 + 4 * i, 32'h5A000000 + i));
    run_cycles(3, "prerst");
    bus.st_valid = 1'b1; bus.st_control = STR_SW; bus.st_addr = 32'h102;
    bus.st_data = 32'h00000055; bus.mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.st_valid = 1'b0;
    #1;
`ifdef STORE_MISALIGN_TRAP_EN
    chk("prerst.misalign_err", bus.misalign_err, 1'b1);
    chk("prerst.count", bus.count, 3);
`else
    chk("prerst.count", bus.count, 4);
    chk("prerst.full", bus.full, 1'b1);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("arst.mem_valid", bus.mem_valid, 1'b0);
    chk("arst.count", bus.count, 0);
    chk("arst.full", bus.full, 1'b0);
    chk("arst.empty", bus.empty, 1'b1);
    chk("arst.misalign_err", bus.misalign_err, 1'b0);
    chk("arst.st_ready", bus.st_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_cycles(2, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
